// File: rtl/reflet_float_pkg.sv
// Shared definitions for the float dispatch slice: field widths, the issue
// FSM encoding and the command record layout.
package reflet_float_pkg;

  localparam int OPCODE_W   = 6;
  localparam int CTRL_W     = 2;
  localparam int FLOAT_SIZE = 32;

  // Issue sequence: LAUNCH and WAIT enable the AU, HOLD presents the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Command record as stored in the FIFO, most significant field first.
  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [CTRL_W-1:0]     ctrl;
    logic [FLOAT_SIZE-1:0] a;
    logic [FLOAT_SIZE-1:0] b;
    logic [FLOAT_SIZE-1:0] c;
  } cmd_t;

  // Flat width of a command for an arbitrary float word width.
  function automatic int cmd_width(input int fs);
    return OPCODE_W + CTRL_W + 3 * fs;
  endfunction

endpackage

// File: rtl/reflet_cmd_fifo.sv
// Synchronous command FIFO with full/empty/count. When empty, the read port
// shows the incoming write data so a push and a pop in the same cycle move
// the command straight through without costing an extra cycle.
module reflet_cmd_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && (!empty || do_push);
  assign pop_data = empty ? push_data : mem_q[rptr_q];

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at depth (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reflet_float_dispatch.sv
// Command queue and issue stage in front of reflet_float_au.
// Optional watchdog: define REFLET_FLOAT_DISPATCH_TIMEOUT_EN to bound WAIT to
// `timeout` cycles; without it res_timeout is tied low and WAIT is unbounded.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Once valid is raised the payload stays stable until that edge; ready may
// be high without valid. cmd_* is accepted when the FIFO is not full;
// res_* stays valid and stable in HOLD until res_ready is seen.
module reflet_float_dispatch
  import reflet_float_pkg::*;
#(
  parameter int float_size = 32,
  parameter int depth      = 4,
  parameter int timeout    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [5:0]            cmd_opcode,
  input  logic [1:0]            cmd_ctrl,
  input  logic [float_size-1:0] cmd_a,
  input  logic [float_size-1:0] cmd_b,
  input  logic [float_size-1:0] cmd_c,
  output logic                  au_enable,
  output logic [5:0]            au_opcode,
  output logic [1:0]            au_ctrl_flag,
  output logic [float_size-1:0] au_in1,
  output logic [float_size-1:0] au_in2,
  output logic [float_size-1:0] au_in3,
  input  logic                  au_ready,
  input  logic                  au_cmp_flag,
  input  logic [float_size-1:0] au_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [float_size-1:0] res_value,
  output logic                  res_cmp,
  output logic                  res_timeout,
  output logic [1:0]            dbg_state
);

  localparam int CMD_W = cmd_width(float_size);

  state_t state_q, state_d;

  logic [CMD_W-1:0]        fifo_wdata;
  logic [CMD_W-1:0]        fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [$clog2(depth):0]  unused_fifo_count;
  logic                    cmd_push;
  logic                    timeout_hit;

  logic [5:0]            iss_opcode_q, iss_opcode_d;
  logic [1:0]            iss_ctrl_q,   iss_ctrl_d;
  logic [float_size-1:0] iss_a_q,      iss_a_d;
  logic [float_size-1:0] iss_b_q,      iss_b_d;
  logic [float_size-1:0] iss_c_q,      iss_c_d;
  logic [float_size-1:0] res_value_q,  res_value_d;
  logic                  res_cmp_q,    res_cmp_d;
  logic                  res_valid_q,  res_valid_d;

  assign cmd_ready  = !fifo_full;
  assign cmd_push   = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_opcode, cmd_ctrl, cmd_a, cmd_b, cmd_c};

  reflet_cmd_fifo #(
    .width (CMD_W),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // Only the enable gates the AU; its operand lines simply hold the last issue.
  assign au_enable    = (state_q == LAUNCH) || (state_q == WAIT);
  assign au_opcode    = iss_opcode_q;
  assign au_ctrl_flag = iss_ctrl_q;
  assign au_in1       = iss_a_q;
  assign au_in2       = iss_b_q;
  assign au_in3       = iss_c_q;
  assign res_valid    = res_valid_q;
  assign res_value    = res_value_q;
  assign res_cmp      = res_cmp_q;
  assign dbg_state    = state_q;

`ifdef REFLET_FLOAT_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             res_timeout_q;

  // The watchdog fires on the last allowed WAIT cycle.
  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_LAST);
  assign res_timeout = res_timeout_q;

  // WAIT cycle counter: held at zero outside WAIT, so LAUNCH restarts it.
  always_ff @(posedge clk) begin
    if (reset || (state_q != WAIT)) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Timeout tag of the captured result; a real ready always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_timeout_q <= 1'b0;
    end else if ((state_q == WAIT) && (au_ready || timeout_hit)) begin
      res_timeout_q <= !au_ready;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign res_timeout    = 1'b0;
  assign unused_timeout = ^timeout;
`endif

  // Next-state and datapath loads for the issue FSM.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    iss_opcode_d = iss_opcode_q;
    iss_ctrl_d   = iss_ctrl_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_c_d      = iss_c_q;
    res_value_d  = res_value_q;
    res_cmp_d    = res_cmp_q;
    res_valid_d  = res_valid_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty || cmd_push) begin
          fifo_pop     = 1'b1;
          iss_opcode_d = fifo_rdata[CMD_W-1 -: 6];
          iss_ctrl_d   = fifo_rdata[CMD_W-7 -: 2];
          iss_a_d      = fifo_rdata[3*float_size-1 -: float_size];
          iss_b_d      = fifo_rdata[2*float_size-1 -: float_size];
          iss_c_d      = fifo_rdata[float_size-1:0];
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        // au_ready deliberately ignored: it may still be the previous op's.
        state_d = WAIT;
      end
      WAIT: begin
        if (au_ready || timeout_hit) begin
          res_value_d = au_ready ? au_result : '0;
          res_cmp_d   = au_ready && au_cmp_flag;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, issue and result registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      iss_opcode_q <= '0;
      iss_ctrl_q   <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_c_q      <= '0;
      res_value_q  <= '0;
      res_cmp_q    <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      iss_opcode_q <= iss_opcode_d;
      iss_ctrl_q   <= iss_ctrl_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_c_q      <= iss_c_d;
      res_value_q  <= res_value_d;
      res_cmp_q    <= res_cmp_d;
      res_valid_q  <= res_valid_d;
    end
  end

endmodule
